// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
package game_pkg;

    localparam int unsigned SCORE_W = 4;

    localparam logic [7:0] KEY_START = 8'h2C;
    localparam logic [7:0] KEY_PAUSE = 8'h29;

    typedef enum logic [4:0] {
        TITLE_ON  = 5'b00000,
        TITLE_OFF = 5'b00001,
        PLAY      = 5'b11000,
        PAUSE     = 5'b11111,
        ROUND_WIN = 5'b10000,
        DRAW      = 5'b10011,
        MATCH_WIN = 5'b10100
    } state_t;

    // Round-win increment that stops at the match target instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] lim);
        return (s < lim) ? s + 1'b1 : s;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Keycode edge detector: one strobe per key press, no repeats while held.
module key_edge_det
    import game_pkg::*;
#(
    parameter logic [7:0] START_CODE = KEY_START,
    parameter logic [7:0] PAUSE_CODE = KEY_PAUSE
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       start_ev,
    output logic       pause_ev
);

    logic [7:0] key_q;

    // Previous-cycle keycode history.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            key_q <= '0;
        else
            key_q <= keycode;
    end

    // Strobe only on the cycle the code first appears.
    always_comb begin
        start_ev = (keycode == START_CODE) && (key_q != START_CODE);
        pause_ev = (keycode == PAUSE_CODE) && (key_q != PAUSE_CODE);
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: title, play, pause, round/draw/match result screens.
module game_flow_ctrl #(
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned FLICKER_HALF  = 64,
    parameter int unsigned WIN_HOLD      = 255,
    parameter int unsigned ROUNDS_TO_WIN = 3,
    parameter logic [7:0]  KEY_START     = game_pkg::KEY_START,
    parameter logic [7:0]  KEY_PAUSE     = game_pkg::KEY_PAUSE
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_tick,
    input  logic [7:0]               keycode,
    input  logic [NUM_PLAYERS-1:0]   die,
    output logic [4:0]               state,
    output logic [CNT_W-1:0]         count_out,
    output logic [1:0]               winner,
    output logic [NUM_PLAYERS-1:0]   alive,
    output logic [4*NUM_PLAYERS-1:0] score,
    output logic                     match_over
);

    import game_pkg::*;

    localparam logic [SCORE_W-1:0] WIN_TARGET = SCORE_W'(ROUNDS_TO_WIN);

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [1:0]                      win_q, win_d;
    logic [NUM_PLAYERS-1:0]          alive_q, alive_d, alive_nx;
    logic [SCORE_W*NUM_PLAYERS-1:0]  score_q, score_d, score_inc;
    logic [2:0]                      n_alive;
    logic [1:0]                      alive_idx;
    logic [SCORE_W-1:0]              win_score;
    logic                            start_ev, pause_ev;
    logic                            counting, flick_done, hold_done;

    key_edge_det #(
        .START_CODE(KEY_START),
        .PAUSE_CODE(KEY_PAUSE)
    ) u_keys (
        .Clk      (Clk),
        .Reset    (Reset),
        .keycode  (keycode),
        .start_ev (start_ev),
        .pause_ev (pause_ev)
    );

    // Survivor analysis of the post-death mask and the score it would produce.
    always_comb begin
        alive_nx  = alive_q & ~die;
        n_alive   = '0;
        alive_idx = '0;
        win_score = '0;
        score_inc = score_q;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            n_alive = n_alive + 3'(alive_nx[i]);
            if (alive_nx[i])
                alive_idx = 2'(i);
        end
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (alive_idx == 2'(i))
                score_inc[i*SCORE_W +: SCORE_W] =
                    sat_inc(score_q[i*SCORE_W +: SCORE_W], WIN_TARGET);
            if (win_q == 2'(i))
                win_score = score_q[i*SCORE_W +: SCORE_W];
        end
    end

    // Next-state, next-output and frame counter logic.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        alive_d = alive_q;
        score_d = score_q;
        cnt_d   = cnt_q;

        counting   = (state_q != PLAY) && (state_q != PAUSE);
        flick_done = frame_tick && (cnt_q == CNT_W'(FLICKER_HALF - 1));
        hold_done  = frame_tick && (cnt_q == CNT_W'(WIN_HOLD - 1));

        unique case (state_q)
            TITLE_ON, TITLE_OFF: begin
                if (start_ev) begin
                    state_d = PLAY;
                    score_d = '0;
                    alive_d = '1;
                end else if (flick_done) begin
                    state_d = (state_q == TITLE_ON) ? TITLE_OFF : TITLE_ON;
                end
            end
            PLAY: begin
                // Deaths outrank a pause press arriving in the same cycle.
                alive_d = alive_nx;
                if (n_alive == 3'd1) begin
                    state_d = ROUND_WIN;
                    win_d   = alive_idx;
                    score_d = score_inc;
                end else if (n_alive == 3'd0) begin
                    state_d = DRAW;
                end else if (pause_ev) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (start_ev)
                    state_d = PLAY;
            end
            ROUND_WIN: begin
                if (win_score == WIN_TARGET) begin
                    state_d = MATCH_WIN;
                end else if (hold_done) begin
                    state_d = PLAY;
                    alive_d = '1;
                end
            end
            DRAW: begin
                if (hold_done) begin
                    state_d = PLAY;
                    alive_d = '1;
                end
            end
            MATCH_WIN: begin
                if (hold_done) begin
                    state_d = TITLE_ON;
                    score_d = '0;
                end
            end
            default: state_d = TITLE_ON;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        else if (!counting)
            cnt_d = '0;
        else if (frame_tick)
            cnt_d = cnt_q + 1'b1;
    end

    // State and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= TITLE_ON;
            cnt_q   <= '0;
            win_q   <= '0;
            alive_q <= '1;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            alive_q <= alive_d;
            score_q <= score_d;
        end
    end

    assign state      = state_q;
    assign count_out  = cnt_q;
    assign winner     = win_q;
    assign alive      = alive_q;
    assign score      = score_q;
    assign match_over = (state_q == MATCH_WIN);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with hand-computed expectations.
module tb_game_flow_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic [7:0] keycode;
    logic [1:0] die;
    logic [4:0] state;
    logic [7:0] count_out;
    logic [1:0] winner;
    logic [1:0] alive;
    logic [7:0] score;
    logic       match_over;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [4:0] S_TON  = 5'b00000;
    localparam logic [4:0] S_TOFF = 5'b00001;
    localparam logic [4:0] S_PLAY = 5'b11000;
    localparam logic [4:0] S_PAUS = 5'b11111;
    localparam logic [4:0] S_RWIN = 5'b10000;
    localparam logic [4:0] S_DRAW = 5'b10011;
    localparam logic [4:0] S_MWIN = 5'b10100;

    always #5 Clk = ~Clk;

    game_flow_ctrl #(
        .NUM_PLAYERS   (2),
        .CNT_W         (8),
        .FLICKER_HALF  (64),
        .WIN_HOLD      (255),
        .ROUNDS_TO_WIN (3),
        .KEY_START     (8'h2C),
        .KEY_PAUSE     (8'h29)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .keycode    (keycode),
        .die        (die),
        .state      (state),
        .count_out  (count_out),
        .winner     (winner),
        .alive      (alive),
        .score      (score),
        .match_over (match_over)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // n video frames, one tick per 4 clocks, tick on the first clock.
    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
            step();
            step();
        end
    endtask

    initial begin
        Reset      = 1'b1;
        frame_tick = 1'b0;
        keycode    = 8'h00;
        die        = 2'b00;
        #12;
        check("rst_state", 32'(state), 32'(S_TON));
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_alive", 32'(alive), 32'h3);
        check("rst_score", 32'(score), 32'h00);
        check("rst_match", 32'(match_over), 32'd0);
        Reset = 1'b0;
        step();

        // Title flicker
        frames(63);
        check("t1_hold_on", 32'(state), 32'(S_TON));
        check("t1_cnt63", 32'(count_out), 32'd63);
        frames(1);
        check("t1_to_off", 32'(state), 32'(S_TOFF));
        check("t1_cnt_clr", 32'(count_out), 32'd0);
        frames(63);
        check("t1_hold_off", 32'(state), 32'(S_TOFF));
        frames(1);
        check("t1_to_on", 32'(state), 32'(S_TON));

        // Start key held
        keycode = 8'h2C;
        step();
        check("t2_play", 32'(state), 32'(S_PLAY));
        check("t2_score", 32'(score), 32'h00);
        check("t2_alive", 32'(alive), 32'h3);
        repeat (9) step();
        check("t2_still_play", 32'(state), 32'(S_PLAY));
        keycode = 8'h00;
        step();

        // Pause / unpause
        keycode = 8'h29;
        step();
        check("t3_pause", 32'(state), 32'(S_PAUS));
        keycode = 8'h00;
        step();
        keycode = 8'h29;
        step();
        check("t3_pause_ign", 32'(state), 32'(S_PAUS));
        keycode = 8'h00;
        die = 2'b01;
        step();
        check("t3_die_ign", 32'(alive), 32'h3);
        check("t3_die_state", 32'(state), 32'(S_PAUS));
        die = 2'b00;
        keycode = 8'h2C;
        step();
        check("t3_unpause", 32'(state), 32'(S_PLAY));
        keycode = 8'h00;
        step();

        // Player 1 wins a round
        die = 2'b01;
        step();
        check("t4_rwin", 32'(state), 32'(S_RWIN));
        check("t4_winner", 32'(winner), 32'd1);
        check("t4_score", 32'(score), 32'h10);
        check("t4_alive", 32'(alive), 32'h2);
        die = 2'b00;
        frames(254);
        check("t4_hold", 32'(state), 32'(S_RWIN));
        check("t4_cnt254", 32'(count_out), 32'd254);
        frames(1);
        check("t4_back_play", 32'(state), 32'(S_PLAY));
        check("t4_alive_rst", 32'(alive), 32'h3);

        // Double death with simultaneous pause edge
        die = 2'b11;
        keycode = 8'h29;
        step();
        check("t5_draw", 32'(state), 32'(S_DRAW));
        check("t5_score", 32'(score), 32'h10);
        check("t5_alive", 32'(alive), 32'h0);
        die = 2'b00;
        keycode = 8'h00;
        frames(255);
        check("t5_back_play", 32'(state), 32'(S_PLAY));
        check("t5_alive_rst", 32'(alive), 32'h3);

        // Player 0 wins the match
        die = 2'b10;
        step();
        check("t6_w1", 32'(score), 32'h11);
        check("t6_w1_winner", 32'(winner), 32'd0);
        die = 2'b00;
        frames(255);
        check("t6_w1_play", 32'(state), 32'(S_PLAY));
        die = 2'b10;
        step();
        check("t6_w2", 32'(score), 32'h12);
        die = 2'b00;
        frames(255);
        die = 2'b10;
        step();
        check("t6_w3_rwin", 32'(state), 32'(S_RWIN));
        check("t6_w3_score", 32'(score), 32'h13);
        check("t6_w3_nomatch", 32'(match_over), 32'd0);
        die = 2'b00;
        step();
        check("t6_mwin", 32'(state), 32'(S_MWIN));
        check("t6_match_over", 32'(match_over), 32'd1);
        check("t6_mwin_winner", 32'(winner), 32'd0);
        frames(254);
        check("t6_mwin_hold", 32'(state), 32'(S_MWIN));
        frames(1);
        check("t6_title", 32'(state), 32'(S_TON));
        check("t6_score_clr", 32'(score), 32'h00);
        check("t6_match_low", 32'(match_over), 32'd0);

        // Asynchronous reset during a result hold
        keycode = 8'h2C;
        step();
        keycode = 8'h00;
        die = 2'b01;
        step();
        die = 2'b00;
        frames(10);
        check("t7_pre_state", 32'(state), 32'(S_RWIN));
        check("t7_pre_cnt", 32'(count_out), 32'd10);
        #2;
        Reset = 1'b1;
        #1;
        check("t7_state", 32'(state), 32'(S_TON));
        check("t7_count", 32'(count_out), 32'd0);
        check("t7_winner", 32'(winner), 32'd0);
        check("t7_alive", 32'(alive), 32'h3);
        check("t7_score", 32'(score), 32'h00);
        Reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
